// File: rtl/display_scanner_pkg.sv
// Shared constants and bundle types for the 4-digit display scanner.
// Reused by the scanner top level and the downstream segment decoder.
package display_scanner_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic DP_OFF = 1'b1;

  typedef logic [1:0] idx_t;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
  } frame_t;
endpackage

// File: rtl/display_scanner_if.sv
// Bus bundle between a value producer and the display scanner.
// master drives value/control, slave drives digit/anode outputs.
interface display_scanner_if;
  logic [15:0] val;
  logic [3:0]  dp_in;
  logic        load;
  logic        en;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp;
  logic        frame_done;

  modport master (
    output val, dp_in, load, en, blank_lz,
    input  nibble, an, dp, frame_done
  );

  modport slave (
    input  val, dp_in, load, en, blank_lz,
    output nibble, an, dp, frame_done
  );
endinterface

// File: rtl/display_scanner_refresh_tick.sv
// Free-running slot counter; tick is high on the last cycle of a slot.
// Wraps 0..REFRESH_DIV-1.
module refresh_tick #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(REFRESH_DIV - 1);

  logic [W-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + W'(1);
  end
endmodule

// File: rtl/display_scanner.sv
// Multiplexed 4-digit scanner with frame-synchronous value update
// and optional leading-zero blanking.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  display_scanner_if.slave  bus
);
  logic        w_tick;
  logic        w_bound;
  logic [3:0]  w_blank;
  logic [3:0]  w_an;
  idx_t        r_idx;
  logic [15:0] r_disp;
  logic [3:0]  r_dpr;
  frame_t      r_pend;
  logic        r_pend_v;
  logic        r_fd;

  refresh_tick #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_bound = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_disp   <= '0;
      r_dpr    <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_fd     <= 1'b0;
    end else begin
      r_fd <= w_bound;
      if (w_tick)
        r_idx <= r_idx + 1'b1;
      // A load on the boundary bypasses pend and drops any older value.
      if (bus.load && w_bound) begin
        r_disp   <= bus.val;
        r_dpr    <= bus.dp_in;
        r_pend_v <= 1'b0;
      end else if (bus.load) begin
        r_pend   <= '{val: bus.val, dp: bus.dp_in};
        r_pend_v <= 1'b1;
      end else if (w_bound && r_pend_v) begin
        r_disp   <= r_pend.val;
        r_dpr    <= r_pend.dp;
        r_pend_v <= 1'b0;
      end
    end
  end

  always_comb begin
    w_blank = '0;
    for (int k = 1; k < NUM_DIGITS; k++)
      w_blank[k] = bus.blank_lz && ((r_disp >> (4 * k)) == '0);
  end

  always_comb begin
    w_an = ANODE_OFF;
    if (bus.en && !w_blank[r_idx])
      w_an[r_idx] = 1'b0;
  end

  assign bus.nibble     = r_disp[{r_idx, 2'b00} +: 4];
  assign bus.an         = w_an;
  assign bus.dp         = w_blank[r_idx] ? DP_OFF : ~r_dpr[r_idx];
  assign bus.frame_done = r_fd;
endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner at REFRESH_DIV = 4 (16-cycle frames).
// Per-cycle scoreboard plus hand-written per-slot frame vectors.
module tb_display_scanner;
  import display_scanner_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_scanner_if bus ();

  display_scanner #(
    .REFRESH_DIV(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] nib;
    logic [15:0] an;
    logic [3:0]  dp;
  } vec_t;

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] an;
    logic       dp;
    logic       fd;
  } sb_t;

  vec_t tbl [4];
  sb_t  q [$];

  int total = 0;
  int bad = 0;

  int          m_cyc = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic [3:0]  m_dpr = '0;
  logic [3:0]  m_pdp = '0;
  logic        m_pv = 1'b0;
  logic        m_fd = 1'b0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, exp, m_cyc);
    end
  endtask

  function automatic sb_t expect_now();
    sb_t e;
    int ix;
    logic [15:0] sh;
    logic [3:0] one;
    logic bl;
    ix = (m_cyc / 4) % 4;
    sh = m_disp >> (4 * ix);
    bl = bus.blank_lz && (ix != 0) && (sh == 16'h0);
    one = 4'b0001;
    e.nib = sh[3:0];
    e.an = (bus.en && !bl) ? ~(one << ix) : ANODE_OFF;
    e.dp = bl ? 1'b1 : ~m_dpr[ix];
    e.fd = m_fd;
    return e;
  endfunction

  task automatic cyc();
    logic b;
    sb_t e;
    sb_t a;
    @(posedge clk);
    #1;
    if (rst) begin
      m_cyc = 0;
      m_disp = '0;
      m_dpr = '0;
      m_pv = 1'b0;
      m_fd = 1'b0;
    end else begin
      b = (m_cyc % 16) == 15;
      m_fd = b;
      if (bus.load && b) begin
        m_disp = bus.val;
        m_dpr = bus.dp_in;
        m_pv = 1'b0;
      end else if (bus.load) begin
        m_pend = bus.val;
        m_pdp = bus.dp_in;
        m_pv = 1'b1;
      end else if (b && m_pv) begin
        m_disp = m_pend;
        m_dpr = m_pdp;
        m_pv = 1'b0;
      end
      m_cyc++;
    end
    bus.load = 1'b0;
    q.push_back(expect_now());
    a = '{nib: bus.nibble, an: bus.an, dp: bus.dp, fd: bus.frame_done};
    e = q.pop_front();
    chk("sb", 16'(a), 16'(e));
  endtask

  task automatic load_now(logic [15:0] v, logic [3:0] d);
    bus.val = v;
    bus.dp_in = d;
    bus.load = 1'b1;
    cyc();
  endtask

  task automatic to_start();
    for (int i = 0; i < 17 && (m_cyc % 16) != 0; i++)
      cyc();
  endtask

  task automatic frame_check(string nm, vec_t v);
    chk({nm, "_fd_start"}, 16'(bus.frame_done), 16'd1);
    for (int s = 0; s < 4; s++) begin
      chk({nm, "_nib"}, 16'(bus.nibble), 16'(v.nib[4*s +: 4]));
      chk({nm, "_an"}, 16'(bus.an), 16'(v.an[4*s +: 4]));
      chk({nm, "_dp"}, 16'(bus.dp), 16'(v.dp[s]));
      if (s == 1)
        chk({nm, "_fd_low"}, 16'(bus.frame_done), 16'd0);
      repeat (4) cyc();
    end
  endtask

  initial begin
    int pulses;
    int start;
    tbl[0] = '{nib: 16'h1234, an: 16'h7BDE, dp: 4'b1111};
    tbl[1] = '{nib: 16'hBBBB, an: 16'h7BDE, dp: 4'b1010};
    tbl[2] = '{nib: 16'h00C0, an: 16'hFFDE, dp: 4'b1111};
    tbl[3] = '{nib: 16'h0000, an: 16'hFFFE, dp: 4'b1110};

    bus.val = 16'h0;
    bus.dp_in = 4'h0;
    bus.load = 1'b0;
    bus.en = 1'b1;
    bus.blank_lz = 1'b0;

    rst = 1'b1;
    load_now(16'hABCD, 4'hF);
    cyc();
    rst = 1'b0;
    chk("rst_nib", 16'(bus.nibble), 16'h0);
    chk("rst_an", 16'(bus.an), 16'hE);
    chk("rst_dp", 16'(bus.dp), 16'h1);
    chk("rst_fd", 16'(bus.frame_done), 16'h0);
    bus.en = 1'b0;
    #1;
    chk("rst_an_en0", 16'(bus.an), 16'hF);
    bus.en = 1'b1;
    #1;

    repeat (5) cyc();
    load_now(16'h1234, 4'h0);
    chk("hold_until_bound", 16'(bus.nibble), 16'h0);
    to_start();
    frame_check("v1234", tbl[0]);

    load_now(16'hAAAA, 4'h0);
    repeat (2) cyc();
    load_now(16'hBBBB, 4'b0101);
    to_start();
    frame_check("vBBBB", tbl[1]);

    bus.blank_lz = 1'b1;
    repeat (3) cyc();
    load_now(16'h5555, 4'h0);
    for (int i = 0; i < 17 && (m_cyc % 16) != 15; i++)
      cyc();
    load_now(16'h00C0, 4'h0);
    frame_check("v00C0", tbl[2]);
    frame_check("v00C0_again", tbl[2]);

    load_now(16'h0000, 4'hF);
    to_start();
    frame_check("v0000", tbl[3]);

    bus.en = 1'b0;
    pulses = 0;
    start = m_cyc;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("en0_an", 16'(bus.an), 16'(ANODE_OFF));
      if (bus.frame_done) begin
        pulses++;
        chk("en0_fd_period", 16'(m_cyc - start), 16'd16);
      end
    end
    chk("en0_pulses", 16'(pulses), 16'd1);
    bus.en = 1'b1;
    to_start();
    frame_check("resume", tbl[3]);

    load_now(16'h9999, 4'h0);
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_nib", 16'(bus.nibble), 16'h0);
    chk("midrst_an", 16'(bus.an), 16'hE);
    chk("midrst_dp", 16'(bus.dp), 16'h1);
    chk("midrst_fd", 16'(bus.frame_done), 16'h0);
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("no_stale_pend", 16'(bus.nibble), 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot, legal range 2..2^20.
REQ-002 clk  input  1  system clock; every register updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 val  input  16  four hex digits; val[3:0] is digit 0 (rightmost), val[15:12] is digit 3.
REQ-005 dp_in  input  4  decimal-point request per digit, 1 = lit.
REQ-006 load  input  1  one-cycle strobe that captures val and dp_in.
REQ-007 en  input  1  display enable; 0 turns all anodes off.
REQ-008 blank_lz  input  1  1 = blank leading zeros.
REQ-009 nibble  output  4  digit code to the downstream 7-segment decoder.
REQ-010 an  output  4  anode enables, active-low, an[k] = digit k.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 frame_done  output  1  one-cycle pulse when digit 3's slot ends.

Function
REQ-013 Slot counter cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; terminal count (TC) SHALL be true when cnt = REFRESH_DIV-1.
REQ-014 Digit index idx (2 bits) SHALL increment modulo 4 on each TC and hold otherwise; the sequence is 0,1,2,3,0.
REQ-015 The block SHALL keep a displayed register disp (16 b), a displayed DP register dpr (4 b), a pending register pend and a flag pend_v.
REQ-016 On load with no frame boundary in that cycle, val and dp_in SHALL go to pend and pend_v SHALL be set to 1; a later load before the boundary overwrites pend (latest value wins).
REQ-017 A frame boundary SHALL be TC with idx = 3; at the boundary, if pend_v = 1, then disp/dpr <= pend and pend_v <= 0.
REQ-018 If load and the frame boundary occur in the same cycle, val and dp_in SHALL go directly to disp/dpr and pend_v SHALL be cleared, so any older pending value is discarded.
REQ-019 nibble SHALL equal disp[4*idx+3 : 4*idx], decoded combinationally from registered state; it is valid in the same cycle idx changes.
REQ-020 dp SHALL equal ~dpr[idx].
REQ-021 an SHALL be all ones except an[idx] = 0; an SHALL be 4'b1111 when en = 0 or the current digit is blanked.
REQ-022 With blank_lz = 1, digit k (k = 3..1) SHALL be blanked when disp digits k..3 are all zero; digit 0 SHALL never be blanked; dp on a blanked digit SHALL be 1.
REQ-023 en SHALL NOT stall cnt, idx or the load path.
REQ-024 frame_done SHALL be registered and SHALL assert the cycle after each frame boundary, high for exactly one cycle.

Reset
REQ-025 When rst = 1 at a clock edge, the block SHALL set cnt = 0, idx = 0, disp = 0, dpr = 0, pend_v = 0 and frame_done = 0; rst SHALL take priority over load and TC in the same cycle.
REQ-026 After reset, outputs SHALL be nibble = 0, dp = 1 and an = 4'b1110 (or 4'b1111 when en = 0); a load made before reset SHALL be lost.

Structure
REQ-027 A shared include file SHALL hold NUM_DIGITS = 4, ANODE_OFF = 4'b1111 and DP_OFF = 1'b1, so the decoder and top level can reuse them.
REQ-028 The slot counter SHALL be a sub-module, refresh_tick (parameter REFRESH_DIV; ports clk, rst, tick).
REQ-029 The rest SHALL stay in display_scanner, with no internal instance of the 7-segment decoder.

Verification (REFRESH_DIV = 4)
REQ-030 Reset, then load val=16'h1234 during digit 1's slot -> no change until the boundary; then, in 4-cycle slots, nibble = 4,3,2,1 with an = 1110, 1101, 1011, 0111.
REQ-031 Load 16'hAAAA, then load 16'hBBBB before the boundary -> next frame shows only B on every digit.
REQ-032 Load 16'h00C0 on the boundary cycle -> next slot shows digit 0 = 0 with no pending carry-over; with blank_lz = 1, an stays 1111 during the digit 2 and 3 slots while digits 1 and 0 light.
REQ-033 disp = 16'h0000 with blank_lz = 1 -> only digit 0 lights (showing 0); dp_in = 4'b1111 -> dp = 0 only in the digit-0 slot.
REQ-034 en = 0 for 20 cycles -> an = 1111 throughout, frame_done still pulses every 16 cycles, and scanning resumes in phase when en returns to 1.
REQ-035 Assert rst mid-frame with a load pending -> the next cycle has idx = 0, nibble = 0, an = 1110 and frame_done = 0, and the pending value is never displayed.
